// File: rtl/reg_mport_ram.sv
// Multi-port register-file RAM: NR registered read ports (1-cycle latency, zero-when-idle), NW byte-masked write ports.
// Optional same-cycle write-to-read forwarding when REG_MPORT_RAM_BYPASS_EN is defined; never stalls.
module reg_mport_ram #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  parameter  int NR    = 2,
  parameter  int NW    = 2,
  parameter  int BW    = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NL    = WIDTH / BW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR-1:0]             re,
  input  logic [NR-1:0][AW-1:0]     ra,
  output logic [NR-1:0][WIDTH-1:0]  rd,
  output logic [NR-1:0]             rvalid,
  input  logic [NW-1:0]             we,
  input  logic [NW-1:0][AW-1:0]     wa,
  input  logic [NW-1:0][NL-1:0]     wbe,
  input  logic [NW-1:0][WIDTH-1:0]  wd
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0][WIDTH-1:0] mem_nxt;
  logic [NR-1:0][WIDTH-1:0]    rsel;

  // Ports applied in ascending order so the highest-index port wins each lane.
  // Only entries 0..DEPTH-1 are matched, so out-of-range writes fall away.
  always_comb begin
    mem_nxt = mem;
    for (int e = 0; e < DEPTH; e++) begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && (wa[j] == AW'(e))) begin
          for (int k = 0; k < NL; k++) begin
            if (wbe[j][k]) begin
              mem_nxt[e][k*BW +: BW] = wd[j][k*BW +: BW];
            end
          end
        end
      end
    end
  end

  // Out-of-range read addresses match no entry and select zero.
  always_comb begin
    rsel = '0;
    for (int i = 0; i < NR; i++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ra[i] == AW'(e)) begin
`ifdef REG_MPORT_RAM_BYPASS_EN
          rsel[i] = mem_nxt[e];
`else
          rsel[i] = mem[e];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      rd     <= '0;
      rvalid <= '0;
    end else begin
      mem    <= mem_nxt;
      rvalid <= re;
      for (int i = 0; i < NR; i++) begin
        rd[i] <= re[i] ? rsel[i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_mport_ram.sv
// Bench for reg_mport_ram (DEPTH=12, 2R/2W): directed scenarios pinned by literals, then random traffic
// checked every cycle against a word-array reference model.
module tb_reg_mport_ram;
  localparam int WIDTH = 32;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int NL    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            re;
  logic [1:0][AW-1:0]    ra;
  logic [1:0][WIDTH-1:0] rd;
  logic [1:0]            rvalid;
  logic [1:0]            we;
  logic [1:0][AW-1:0]    wa;
  logic [1:0][NL-1:0]    wbe;
  logic [1:0][WIDTH-1:0] wd;

  int checks = 0;
  int errors = 0;

  reg_mport_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(2), .NW(2), .BW(8)) dut (
    .clk(clk), .rst(rst), .re(re), .ra(ra), .rd(rd), .rvalid(rvalid),
    .we(we), .wa(wa), .wbe(wbe), .wd(wd)
  );

  always #5 clk = ~clk;

  // Reference model: plain word array, writes applied port by port in order.
  logic [WIDTH-1:0] model [DEPTH];
  logic [1:0][WIDTH-1:0] exp_rd;
  logic [1:0]            exp_rv;
  bit                    model_ok = 1'b0;

  always @(posedge clk) begin
    logic [WIDTH-1:0] pre  [DEPTH];
    logic [WIDTH-1:0] post [DEPTH];
    for (int e = 0; e < DEPTH; e++) pre[e] = model[e];
    for (int e = 0; e < DEPTH; e++) post[e] = model[e];
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) post[e] = '0;
      exp_rd = '0;
      exp_rv = '0;
    end else begin
      for (int j = 0; j < 2; j++)
        if (we[j] && int'(wa[j]) < DEPTH)
          for (int k = 0; k < NL; k++)
            if (wbe[j][k]) post[wa[j]][k*8 +: 8] = wd[j][k*8 +: 8];
      for (int i = 0; i < 2; i++) begin
        exp_rv[i] = re[i];
        exp_rd[i] = '0;
        if (re[i] && int'(ra[i]) < DEPTH) begin
`ifdef REG_MPORT_RAM_BYPASS_EN
          exp_rd[i] = post[ra[i]];
`else
          exp_rd[i] = pre[ra[i]];
`endif
        end
      end
    end
    for (int e = 0; e < DEPTH; e++) model[e] = post[e];
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd[i] !== exp_rd[i] || rvalid[i] !== exp_rv[i]) begin
          errors++;
          $display("FAIL model port%0d t=%0t: rd=%h rvalid=%b, expected rd=%h rvalid=%b",
                   i, $time, rd[i], rvalid[i], exp_rd[i], exp_rv[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    re = '0; ra = '0; we = '0; wa = '0; wbe = '0; wd = '0;
  endtask

  initial begin
    idle();
    // Reset with a write pending: must be ignored
    rst = 1'b1;
    we[0] = 1'b1; wa[0] = 4'd3; wbe[0] = 4'hF; wd[0] = 32'hCAFEF00D;
    cycle();
    cycle();
    chk("reset_rd0", rd[0], '0);
    chk("reset_rd1", rd[1], '0);
    chk("reset_rvalid", {30'd0, rvalid}, '0);
    rst = 1'b0;
    idle();
    re = 2'b11; ra[0] = 4'd3; ra[1] = 4'd3;
    cycle();
    chk("post_reset_rvalid", {30'd0, rvalid}, 32'd3);
    chk("post_reset_rd0", rd[0], '0);
    chk("post_reset_rd1", rd[1], '0);

    // Byte-lane write
    idle();
    we[0] = 1'b1; wa[0] = 4'd5; wbe[0] = 4'hF; wd[0] = 32'hAABBCCDD;
    cycle();
    wbe[0] = 4'b0101; wd[0] = 32'h11223344;
    cycle();
    idle();
    re[0] = 1'b1; ra[0] = 4'd5;
    cycle();
    chk("byte_lane", rd[0], 32'hAA22CC44);

    // Same-cycle conflict: port1 owns lane 0
    idle();
    we = 2'b11; wa[0] = 4'd2; wa[1] = 4'd2;
    wbe[0] = 4'hF; wd[0] = 32'h12345678;
    wbe[1] = 4'b0001; wd[1] = 32'h000000FF;
    cycle();
    idle();
    re[1] = 1'b1; ra[1] = 4'd2;
    cycle();
    chk("conflict", rd[1], 32'h123456FF);

    // Same-cycle read/write on addr 7
    idle();
    we[0] = 1'b1; wa[0] = 4'd7; wbe[0] = 4'hF; wd[0] = 32'hDEADBEEF;
    re[0] = 1'b1; ra[0] = 4'd7;
    cycle();
`ifdef REG_MPORT_RAM_BYPASS_EN
    chk("rw_same_cycle", rd[0], 32'hDEADBEEF);
`else
    chk("rw_same_cycle", rd[0], 32'h0);
`endif
    idle();
    re[0] = 1'b1; ra[0] = 4'd7;
    cycle();
    chk("rw_next_cycle", rd[0], 32'hDEADBEEF);

    // Out-of-range read and write, port1 idle
    idle();
    re[0] = 1'b1; ra[0] = 4'd13;
    we[0] = 1'b1; wa[0] = 4'd14; wbe[0] = 4'hF; wd[0] = 32'hFFFFFFFF;
    cycle();
    chk("oor_rd0", rd[0], '0);
    chk("oor_rvalid0", {31'd0, rvalid[0]}, 32'd1);
    chk("idle_rd1", rd[1], '0);
    chk("idle_rvalid1", {31'd0, rvalid[1]}, '0);
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      re = 2'b11; ra[0] = AW'(a); ra[1] = AW'(a);
      cycle();
    end
    chk("sweep_last_rd", rd[0], '0);

    // Back-to-back streaming with interleaved writes elsewhere
    for (int a = 0; a < DEPTH; a++) begin
      re = 2'b11; ra[0] = AW'(a); ra[1] = AW'(DEPTH - 1 - a);
      we = 2'b01; wa[0] = AW'((a + 6) % DEPTH); wbe[0] = 4'(($urandom_range(0, 15)));
      wd[0] = $urandom;
      cycle();
      chk("stream_rvalid", {30'd0, rvalid}, 32'd3);
    end

    // Random traffic, addresses biased toward collisions
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      re  = 2'($urandom);
      we  = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        ra[p]  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
        wa[p]  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
        wbe[p] = 4'($urandom);
        wd[p]  = $urandom;
      end
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_mport_ram.md
# reg_mport_ram

Parametrised multi-port register-file RAM for L1D metadata and small data arrays. It supersedes the single-read/single-write combinational-read register RAM. Features:
- NR independent read ports with a registered, one-cycle-latency output and a valid flag.
- NW write ports with byte-lane masks and fixed per-lane priority.
- Optional same-cycle write-to-read forwarding.

## Interface
Parameters:
- WIDTH, default 32: entry width in bits; must be a multiple of BW.
- DEPTH, default 16: number of entries; need not be a power of two.
- NR, default 2: number of read ports, 1 or more.
- NW, default 2: number of write ports, 1 or more.
- BW, default 8: byte-lane width in bits.
- Derived: AW = max(1, $clog2(DEPTH)); NL = WIDTH/BW.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- re  in  [NR-1:0]  per-port read enable.
- ra  in  [NR-1:0][AW-1:0]  read addresses.
- rd  out  [NR-1:0][WIDTH-1:0]  registered read data.
- rvalid  out  [NR-1:0]  rd[i] holds data for the request made in the previous cycle.
- we  in  [NW-1:0]  per-port write enable.
- wa  in  [NW-1:0][AW-1:0]  write addresses.
- wbe  in  [NW-1:0][NL-1:0]  per-port byte-lane enables.
- wd  in  [NW-1:0][WIDTH-1:0]  write data.

## Operation
**Storage**
- DEPTH×WIDTH flops, organised as NL lanes of BW bits each.

**Write**
- Port j updates lane k of entry wa[j] when we[j] && wbe[j][k].
- Lanes with wbe=0 keep their value. we=1 with wbe all-zero is a no-op.

**Write conflicts**
- Several ports writing the same entry and lane in one cycle: the highest-index port j wins, resolved per lane.
- Example: port0 writes lanes 0-3 and port1 writes lane 0 of the same entry. Lane 0 takes port1's data; lanes 1-3 take port0's data.

**Read**
- Port i samples ra[i] when re[i]=1.
- On the next clock, rd[i] is loaded with the entry and rvalid[i] is set to 1.
- If re[i]=0, the next clock sets rd[i]=0 and rvalid[i]=0 (zero-when-idle).

**Out-of-range addresses** (address >= DEPTH)
- Writes are dropped for all lanes.
- Reads return 0 with rvalid=1.

**Multiple reads**
- Read ports are fully independent; any number of ports may read the same address.

**Reset**
- While rst=1, every entry is cleared to 0 on each clock. rd=0 and rvalid=0 for all ports.
- rst has priority over re and we in the same cycle.

## Timing
- Read latency: exactly 1 cycle, from the re/ra sample edge to rd/rvalid.
- Read throughput: one read per port per cycle, with no stalls.
- Write latency: the write is committed at the clock edge where we=1.
- A read at cycle t+1 of an entry written at cycle t returns the new data, irrespective of the macro.
- Read and write of the same address in the same cycle t: the result visible on rd at t+1 is set by Configuration.
- First clock after rst deasserts: reads accepted immediately and return 0; writes accepted immediately.
- Reset values: rd=0 and rvalid=0 for all ports; all entries 0.
- No combinational path from inputs to outputs.

## Configuration
- Macro: REG_MPORT_RAM_BYPASS_EN.
- **Defined:** same-cycle forwarding. For each read port, each lane of rd at t+1 is the post-write value of that lane after cycle t's writes, using the same per-lane priority. Forwarding applies only to in-range addresses.
- **Undefined:** no forwarding. A same-cycle read returns the pre-write contents. There is no write-to-read logic in the read path.

## Test plan
1. **Reset, then read.** Stimulus: assert rst for 2 cycles while we[0]=1; then read addr 3 on both ports. Required: rd=0 and rvalid=0 during reset; one cycle after the read, rvalid=2'b11 and rd=0. The write during reset has no effect.
2. **Byte-lane write.** Stimulus: write 0xAABBCCDD to addr 5 with wbe=4'hF; then write 0x11223344 with wbe=4'b0101. Required: a later read of addr 5 returns 0xAA22CC44.
3. **Same-cycle write conflict.** Stimulus: port0 writes 0x12345678 to addr 2 with wbe=4'hF; port1 writes 0x000000FF to addr 2 with wbe=4'b0001, same cycle. Required: a read returns 0x123456FF.
4. **Same-cycle read/write.** Stimulus: addr 7 holds 0x0; in one cycle, write 0xDEADBEEF to addr 7 and read addr 7. Required: with REG_MPORT_RAM_BYPASS_EN, rd=0xDEADBEEF at t+1; without it, rd=0x0 at t+1 and 0xDEADBEEF on a read at t+1.
5. **Idle and out-of-range.** Configuration DEPTH=12. Stimulus: read addr 13 on port0 while re[1]=0; write addr 14. Required: rd[0]=0 with rvalid[0]=1; rd[1]=0 with rvalid[1]=0; no entry is modified (checked by sweeping all entries).
6. **Back-to-back streaming.** Stimulus: read addrs 0..DEPTH-1 on consecutive cycles on both ports, with interleaved writes to different addresses. Required: every cycle produces rvalid=1 with the correct data at 1-cycle latency, with no bubbles.
